// File: rtl/fc_in_loader.sv
// Streaming activation loader for the fully-parallel FC layer. It assembles IN samples
// into a register bank, zero-pads short frames and holds the vector until the consumer takes it.
module fc_in_loader #(
    parameter int WIDTH = 8,
    parameter int IN    = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         s_data,
    input  logic                     s_valid,
    input  logic                     s_last,
    output logic                     s_ready,
    output logic [WIDTH-1:0]         x [0:IN-1],
    output logic                     x_valid,
    input  logic                     x_ready,
    output logic [$clog2(IN+1)-1:0]  vec_len,
    output logic                     len_err
);

    localparam int CNT_W = (IN > 1) ? $clog2(IN) : 1;
    localparam int LEN_W = $clog2(IN + 1);

    localparam logic [1:0] S_FILL = 2'd0;
    localparam logic [1:0] S_PAD  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN - 1);
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(IN);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_buf [0:IN-1];
    logic [LEN_W-1:0] r_vec_len;
    logic             r_len_err;
    logic             w_accept;

    assign s_ready  = (r_state == S_FILL) && rst_n;
    assign x_valid  = (r_state == S_HOLD);
    assign x        = r_buf;
    assign vec_len  = r_vec_len;
    assign len_err  = r_len_err;
    assign w_accept = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FILL;
            r_cnt     <= '0;
            r_buf     <= '{default: '0};
            r_vec_len <= '0;
            r_len_err <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        r_buf[r_cnt] <= s_data;
                        if (r_cnt == CNT_LAST) begin
                            // A full bank is presented even when the source forgot s_last.
                            r_state   <= S_HOLD;
                            r_vec_len <= LEN_FULL;
                            if (!s_last) begin
                                r_len_err <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            if (s_last) begin
                                r_vec_len <= LEN_W'(r_cnt) + LEN_W'(1);
                                r_state   <= S_PAD;
                            end
                        end
                    end
                end
                S_PAD: begin
                    // Zero-fill every unused slot so stale entries never reach the adder tree.
                    r_buf[r_cnt] <= '0;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (x_ready) begin
                        r_cnt   <= '0;
                        r_state <= S_FILL;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_in_loader.sv
// Self-checking bench for fc_in_loader: directed frames from the test plan plus random
// frames, checked against a frame-level model (accepted samples, zero padding, sticky error).
module tb_fc_in_loader;

    localparam int WIDTH = 8;
    localparam int IN    = 128;
    localparam int LW    = $clog2(IN + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic [WIDTH-1:0] x [0:IN-1];
    logic             x_valid;
    logic             x_ready;
    logic [LW-1:0]    vec_len;
    logic             len_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] frame [$];
    logic [WIDTH-1:0] exp_vec [0:IN-1];
    int               exp_len;
    bit               exp_len_err;

    always #5 clk = ~clk;

    fc_in_loader #(.WIDTH(WIDTH), .IN(IN)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .x       (x),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .vec_len (vec_len),
        .len_err (len_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int vec_mism();
        int m = 0;
        for (int i = 0; i < IN; i++) begin
            if (x[i] !== exp_vec[i]) m++;
        end
        return m;
    endfunction

    // Model: the held vector is the accepted samples followed by zeros.
    task automatic build_expected(input bit mark_last);
        for (int i = 0; i < IN; i++) begin
            exp_vec[i] = (i < frame.size()) ? frame[i] : '0;
        end
        exp_len = frame.size();
        if (frame.size() == IN && !mark_last) exp_len_err = 1'b1;
    endtask

    task automatic send_frame(input int gap_max, input bit mark_last);
        int  i = 0;
        int  guard = 0;
        bit  acc;
        while (i < frame.size() && guard < 20 * IN) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(gap_max, 0)) begin
                    s_valid = 1'b0;
                    s_data  = WIDTH'($urandom);
                    tick();
                end
            end
            s_valid = 1'b1;
            s_data  = frame[i];
            s_last  = mark_last && (i == frame.size() - 1);
            acc     = s_ready;
            tick();
            if (acc) i++;
            guard++;
        end
        chk("send_done", i, frame.size());
    endtask

    task automatic check_held(input string tag);
        chk({tag, "_xvalid"}, x_valid, 1);
        chk({tag, "_veclen"}, vec_len, exp_len);
        chk({tag, "_lenerr"}, len_err, exp_len_err);
        chk({tag, "_vec"}, vec_mism(), 0);
    endtask

    task automatic await_vector(input string tag, input int exp_lat);
        int lat = 0;
        int rdy_hi = 0;
        while (!x_valid && lat <= 2 * IN) begin
            if (s_ready) rdy_hi++;
            s_valid = 1'($urandom);
            s_data  = WIDTH'($urandom);
            s_last  = 1'($urandom);
            tick();
            lat++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_rdy_pad"}, rdy_hi, 0);
        check_held(tag);
    endtask

    task automatic present(input string tag, input int gap_max, input bit mark_last);
        send_frame(gap_max, mark_last);
        build_expected(mark_last);
        await_vector(tag, (frame.size() == IN) ? 0 : IN - frame.size());
    endtask

    task automatic release_vec(input string tag);
        s_valid = 1'b0;
        x_ready = 1'b1;
        tick();
        x_ready = 1'b0;
        chk({tag, "_rel_xvalid"}, x_valid, 0);
        chk({tag, "_rel_sready"}, s_ready, 1);
    endtask

    initial begin
        int n;
        bit ml;
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; x_ready = 1'b0;
        exp_len_err = 1'b0;
        tick();
        tick();
        for (int i = 0; i < IN; i++) exp_vec[i] = '0;
        chk("rst_sready", s_ready, 0);
        chk("rst_xvalid", x_valid, 0);
        chk("rst_veclen", vec_len, 0);
        chk("rst_lenerr", len_err, 0);
        chk("rst_vec", vec_mism(), 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_sready", s_ready, 1);

        // 1: full frame data=i with s_last on the final beat
        frame.delete();
        for (int i = 0; i < IN; i++) frame.push_back(WIDTH'(i));
        present("full", 0, 1'b1);
        release_vec("full");

        // 2: short frame of 5
        frame = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        present("short5", 0, 1'b1);
        release_vec("short5");

        // 3: backpressure in HOLD
        frame.delete();
        for (int i = 0; i < IN; i++) frame.push_back(WIDTH'($urandom));
        present("bp", 0, 1'b1);
        for (int c = 0; c < 50; c++) begin
            s_valid = 1'b1;
            s_data  = WIDTH'($urandom);
            tick();
            chk("bp_sready", s_ready, 0);
            chk("bp_xvalid", x_valid, 1);
            chk("bp_veclen", vec_len, exp_len);
            chk("bp_vec", vec_mism(), 0);
        end
        release_vec("bp");

        // 4: 128 beats of 0xA5 without s_last
        frame.delete();
        for (int i = 0; i < IN; i++) frame.push_back(8'hA5);
        present("nolast", 0, 1'b0);
        release_vec("nolast");

        // 5: full 0xFF frame, then 3-beat frame with gaps over it
        frame.delete();
        for (int i = 0; i < IN; i++) frame.push_back(8'hFF);
        present("ff", 2, 1'b1);
        release_vec("ff");
        frame = '{8'h01, 8'h02, 8'h03};
        present("stale3", 4, 1'b1);
        release_vec("stale3");

        // 6: reset in the middle of a fill
        frame.delete();
        for (int i = 0; i < 40; i++) frame.push_back(8'h7E);
        send_frame(0, 1'b0);
        s_valid = 1'b0;
        chk("midfill_xvalid", x_valid, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_sready", s_ready, 0);
        tick();
        exp_len_err = 1'b0;
        for (int i = 0; i < IN; i++) exp_vec[i] = '0;
        chk("midrst_xvalid", x_valid, 0);
        chk("midrst_sready2", s_ready, 0);
        chk("midrst_vec", vec_mism(), 0);
        chk("midrst_veclen", vec_len, 0);
        chk("midrst_lenerr", len_err, 0);
        rst_n = 1'b1;
        #1;
        chk("midrst_rel_sready", s_ready, 1);
        frame = '{8'hC3, 8'h3C};
        present("two", 0, 1'b1);
        release_vec("two");

        // Random frames of random length, data and gaps
        for (int f = 0; f < 10; f++) begin
            n  = $urandom_range(IN, 1);
            ml = (n < IN) ? 1'b1 : 1'($urandom);
            frame.delete();
            for (int i = 0; i < n; i++) frame.push_back(WIDTH'($urandom));
            present($sformatf("rnd%0d", f), $urandom_range(2, 0), ml);
            repeat ($urandom_range(3, 0)) begin
                tick();
                chk("rnd_hold_vec", vec_mism(), 0);
            end
            release_vec($sformatf("rnd%0d", f));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
